// File: rtl/pmt_pulse_qualifier.sv
// pmt_pulse_qualifier
//   Brings the asynchronous PMT discriminator output into the main_clock domain.
//   Pulses shorter than MIN_WIDTH samples are rejected as glitches, and rising
//   edges inside a dead time after each accepted pulse are also rejected. Each
//   accepted pulse is tagged with in-phase/quadrature reference bits and produces
//   a single-cycle event strobe for the downstream I/Q counters.
// Ports
//   main_clock, reset      clock and synchronous active-high reset
//   enable                 0 holds the qualifier idle and discards in-flight pulses
//   clear_counts           synchronous clear of the diagnostic counters
//   PMT_in                 raw asynchronous discriminator input
//   ref_flag, ref_timer    modulation phase reference
//   event_valid            1-cycle strobe per accepted pulse
//   event_in_phase/_quadrature  tags, updated on each event and held between events
//   *_count                saturating diagnostic counters
module pmt_pulse_qualifier #(
  parameter int unsigned MIN_WIDTH   = 2,
  parameter int unsigned DEAD_TIME   = 10,
  parameter int unsigned HALF_PERIOD = 250,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   main_clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear_counts,
  input  logic                   PMT_in,
  input  logic                   ref_flag,
  input  logic [31:0]            ref_timer,
  output logic                   event_valid,
  output logic                   event_in_phase,
  output logic                   event_quadrature,
  output logic [COUNT_WIDTH-1:0] accepted_count,
  output logic [COUNT_WIDTH-1:0] glitch_reject_count,
  output logic [COUNT_WIDTH-1:0] deadtime_reject_count
);

  localparam int unsigned WW = $clog2(MIN_WIDTH + 1);
  localparam int unsigned DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [31:0] QuarterPoint = 32'(HALF_PERIOD / 2);

  typedef enum logic [1:0] {StIdle, StQualify, StDead} state_e;

  state_e                 state_q, state_d;
  logic                   s1_q, s2_q, s3_q;
  logic [WW-1:0]          width_cnt_q, width_cnt_d;
  logic [DW-1:0]          dead_cnt_q, dead_cnt_d;
  logic                   pend_i_q, pend_i_d, pend_q_q, pend_q_d;
  logic                   ev_valid_q, ev_valid_d;
  logic                   ev_i_q, ev_i_d, ev_q_q, ev_q_d;
  logic [COUNT_WIDTH-1:0] acc_q, acc_d, glitch_q, glitch_d, dead_rej_q, dead_rej_d;

  logic rise, tag_i, tag_q, emit, glitch_inc, dead_inc;

  function automatic logic [COUNT_WIDTH-1:0] next_count(input logic [COUNT_WIDTH-1:0] cnt,
                                                        input logic inc, input logic clr);
    logic [COUNT_WIDTH-1:0] res;
    res = cnt;
    if (clr) begin
      res = '0;
    end else if (inc && (cnt != '1)) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

  assign rise  = s2_q & ~s3_q;
  assign tag_i = ref_flag;
  assign tag_q = ref_flag ? (ref_timer >= QuarterPoint) : (ref_timer < QuarterPoint);

  always_comb begin
    state_d     = state_q;
    width_cnt_d = width_cnt_q;
    dead_cnt_d  = dead_cnt_q;
    pend_i_d    = pend_i_q;
    pend_q_d    = pend_q_q;
    ev_valid_d  = 1'b0;
    ev_i_d      = ev_i_q;
    ev_q_d      = ev_q_q;
    emit        = 1'b0;
    glitch_inc  = 1'b0;
    dead_inc    = 1'b0;

    if (!enable) begin
      // Disabled: drop any pulse in flight without counting it.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            pend_i_d    = tag_i;
            pend_q_d    = tag_q;
            width_cnt_d = WW'(1);
            if (MIN_WIDTH == 1) begin
              emit   = 1'b1;
              ev_i_d = tag_i;
              ev_q_d = tag_q;
            end else begin
              state_d = StQualify;
            end
          end
        end
        StQualify: begin
          if (s2_q) begin
            // Reaching MIN_WIDTH-1 here means this sample is the MIN_WIDTH-th high one.
            if (width_cnt_q == WW'(MIN_WIDTH - 1)) begin
              emit   = 1'b1;
              ev_i_d = pend_i_q;
              ev_q_d = pend_q_q;
            end else begin
              width_cnt_d = width_cnt_q + 1'b1;
            end
          end else begin
            glitch_inc = 1'b1;
            state_d    = StIdle;
          end
        end
        StDead: begin
          if (rise) begin
            dead_inc = 1'b1;
          end
          if (dead_cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            dead_cnt_d = dead_cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (emit) begin
        ev_valid_d = 1'b1;
        if (DEAD_TIME == 0) begin
          state_d = StIdle;
        end else begin
          state_d    = StDead;
          dead_cnt_d = DW'(DEAD_TIME);
        end
      end
    end

    acc_d      = next_count(acc_q, emit, clear_counts);
    glitch_d   = next_count(glitch_q, glitch_inc, clear_counts);
    dead_rej_d = next_count(dead_rej_q, dead_inc, clear_counts);
  end

  always_ff @(posedge main_clock) begin
    if (reset) begin
      // Sync chain resets high so a level held through reset is not seen as an edge.
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      s3_q        <= 1'b1;
      state_q     <= StIdle;
      width_cnt_q <= '0;
      dead_cnt_q  <= '0;
      pend_i_q    <= 1'b0;
      pend_q_q    <= 1'b0;
      ev_valid_q  <= 1'b0;
      ev_i_q      <= 1'b0;
      ev_q_q      <= 1'b0;
      acc_q       <= '0;
      glitch_q    <= '0;
      dead_rej_q  <= '0;
    end else begin
      s1_q        <= PMT_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      state_q     <= state_d;
      width_cnt_q <= width_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      pend_i_q    <= pend_i_d;
      pend_q_q    <= pend_q_d;
      ev_valid_q  <= ev_valid_d;
      ev_i_q      <= ev_i_d;
      ev_q_q      <= ev_q_d;
      acc_q       <= acc_d;
      glitch_q    <= glitch_d;
      dead_rej_q  <= dead_rej_d;
    end
  end

  assign event_valid           = ev_valid_q;
  assign event_in_phase        = ev_i_q;
  assign event_quadrature      = ev_q_q;
  assign accepted_count        = acc_q;
  assign glitch_reject_count   = glitch_q;
  assign deadtime_reject_count = dead_rej_q;

endmodule

// File: tb/tb_pmt_pulse_qualifier.sv
// Directed bench for pmt_pulse_qualifier. dut uses the default parameters
// (MIN_WIDTH=2, DEAD_TIME=10); dut2 uses MIN_WIDTH=1, DEAD_TIME=0 and 2-bit
// counters so saturation can be reached with a handful of pulses.
module tb_pmt_pulse_qualifier;

  logic        clk = 1'b0;
  logic        rst, en, clr, pmt, pmt2, rflag;
  logic [31:0] rtimer;
  logic        ev, ei, eq;
  logic [31:0] acc, gl, dr;
  logic        ev2, ei2, eq2;
  logic [1:0]  acc2, gl2, dr2;

  int vec  = 0;
  int errs = 0;
  int ev_seen  = 0;
  int ev2_seen = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ev === 1'b1) ev_seen <= ev_seen + 1;
    if (ev2 === 1'b1) ev2_seen <= ev2_seen + 1;
  end

  pmt_pulse_qualifier dut (
    .main_clock(clk), .reset(rst), .enable(en), .clear_counts(clr), .PMT_in(pmt),
    .ref_flag(rflag), .ref_timer(rtimer), .event_valid(ev), .event_in_phase(ei),
    .event_quadrature(eq), .accepted_count(acc), .glitch_reject_count(gl),
    .deadtime_reject_count(dr)
  );

  pmt_pulse_qualifier #(
    .MIN_WIDTH(1), .DEAD_TIME(0), .HALF_PERIOD(250), .COUNT_WIDTH(2)
  ) dut2 (
    .main_clock(clk), .reset(rst), .enable(en), .clear_counts(clr), .PMT_in(pmt2),
    .ref_flag(rflag), .ref_timer(rtimer), .event_valid(ev2), .event_in_phase(ei2),
    .event_quadrature(eq2), .accepted_count(acc2), .glitch_reject_count(gl2),
    .deadtime_reject_count(dr2)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_all();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; pmt = 1'b1; pmt2 = 1'b1; rflag = 1'b0; rtimer = 0;
    tick(3);
    vec++; if (ev !== 1'b0) begin errs++; $display("FAIL reset_ev got %b want 0", ev); end
    vec++; if (ei !== 1'b0) begin errs++; $display("FAIL reset_ei got %b want 0", ei); end
    vec++; if (eq !== 1'b0) begin errs++; $display("FAIL reset_eq got %b want 0", eq); end
    vec++; if (acc !== 0) begin errs++; $display("FAIL reset_acc got %0d want 0", acc); end
    vec++; if (gl !== 0) begin errs++; $display("FAIL reset_gl got %0d want 0", gl); end
    vec++; if (dr !== 0) begin errs++; $display("FAIL reset_dr got %0d want 0", dr); end
    vec++; if (acc2 !== 2'd0) begin errs++; $display("FAIL reset_acc2 got %0d want 0", acc2); end
    // Input held high across reset release must not produce an event.
    rst = 1'b0;
    tick(8);
    vec++; if (ev_seen !== 0) begin errs++; $display("FAIL reset_hi_ev got %0d want 0", ev_seen); end
    vec++; if (ev2_seen !== 0) begin errs++; $display("FAIL reset_hi_ev2 got %0d want 0", ev2_seen); end
    pmt = 1'b0; pmt2 = 1'b0;
    tick(4);
  endtask

  task automatic test_basic();
    int base;
    base = ev_seen;
    rflag = 1'b1; rtimer = 200;
    pmt = 1'b1;
    tick(3);  // edges k..k+2
    vec++; if (ev !== 1'b0) begin errs++; $display("FAIL basic_early got %b want 0", ev); end
    tick(1);  // k+3
    vec++; if (ev !== 1'b1) begin errs++; $display("FAIL basic_ev got %b want 1", ev); end
    vec++; if (ei !== 1'b1) begin errs++; $display("FAIL basic_i got %b want 1", ei); end
    vec++; if (eq !== 1'b1) begin errs++; $display("FAIL basic_q got %b want 1", eq); end
    vec++; if (acc !== 1) begin errs++; $display("FAIL basic_acc got %0d want 1", acc); end
    tick(1);  // k+4
    vec++; if (ev !== 1'b0) begin errs++; $display("FAIL basic_1cyc got %b want 0", ev); end
    pmt = 1'b0; rflag = 1'b0; rtimer = 0;
    tick(20);
    vec++; if (ei !== 1'b1) begin errs++; $display("FAIL basic_hold got %b want 1", ei); end
    vec++; if (acc !== 1) begin errs++; $display("FAIL basic_acc2 got %0d want 1", acc); end
    vec++; if (ev_seen - base !== 1) begin
      errs++; $display("FAIL basic_count got %0d want 1", ev_seen - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    clear_all();
    base = ev_seen;
    pmt = 1'b1; tick(1); pmt = 1'b0;
    tick(8);
    vec++; if (gl !== 1) begin errs++; $display("FAIL glitch_gl got %0d want 1", gl); end
    vec++; if (acc !== 0) begin errs++; $display("FAIL glitch_acc got %0d want 0", acc); end
    vec++; if (ev_seen - base !== 0) begin
      errs++; $display("FAIL glitch_ev got %0d want 0", ev_seen - base);
    end
  endtask

  // Two 3-cycle pulses; gap g low cycles gives rises 3+g apart.
  task automatic test_deadtime();
    int gaps [4]  = '{3, 9, 10, 11};
    int exp_e [4] = '{1, 1, 2, 2};
    int exp_d [4] = '{1, 1, 0, 0};
    int base;
    for (int i = 0; i < 4; i++) begin
      clear_all();
      base = ev_seen;
      pmt = 1'b1; tick(3); pmt = 1'b0; tick(gaps[i]);
      pmt = 1'b1; tick(3); pmt = 1'b0; tick(20);
      vec++; if (ev_seen - base !== exp_e[i]) begin
        errs++; $display("FAIL dead_ev[%0d] got %0d want %0d", i, ev_seen - base, exp_e[i]);
      end
      vec++; if (dr !== exp_d[i]) begin
        errs++; $display("FAIL dead_dr[%0d] got %0d want %0d", i, dr, exp_d[i]);
      end
      vec++; if (acc !== exp_e[i]) begin
        errs++; $display("FAIL dead_acc[%0d] got %0d want %0d", i, acc, exp_e[i]);
      end
    end
  endtask

  task automatic test_tags();
    logic        flags [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    int unsigned timers [4] = '{10, 130, 10, 130};
    logic        exp_i [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_q [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    int base;
    for (int i = 0; i < 4; i++) begin
      rflag = flags[i]; rtimer = timers[i];
      base = ev_seen;
      pmt = 1'b1; tick(3); pmt = 1'b0; tick(18);
      vec++; if (ei !== exp_i[i]) begin
        errs++; $display("FAIL tag_i[%0d] got %b want %b", i, ei, exp_i[i]);
      end
      vec++; if (eq !== exp_q[i]) begin
        errs++; $display("FAIL tag_q[%0d] got %b want %b", i, eq, exp_q[i]);
      end
      vec++; if (ev_seen - base !== 1) begin
        errs++; $display("FAIL tag_ev[%0d] got %0d want 1", i, ev_seen - base);
      end
    end
  endtask

  task automatic test_clear_on_emit();
    int base;
    clear_all();
    base = ev_seen;
    rflag = 1'b1; rtimer = 200;
    pmt = 1'b1; tick(2); pmt = 1'b0;
    tick(1);            // k+2
    clr = 1'b1; tick(1); clr = 1'b0;  // emit edge k+3
    vec++; if (ev !== 1'b1) begin errs++; $display("FAIL clr_ev got %b want 1", ev); end
    vec++; if (acc !== 0) begin errs++; $display("FAIL clr_acc got %0d want 0", acc); end
    tick(20);
    vec++; if (acc !== 0) begin errs++; $display("FAIL clr_acc2 got %0d want 0", acc); end
    vec++; if (ev_seen - base !== 1) begin
      errs++; $display("FAIL clr_count got %0d want 1", ev_seen - base);
    end
  endtask

  task automatic test_saturation();
    int base;
    clear_all();
    base = ev2_seen;
    pmt2 = 1'b1; tick(2);  // k, k+1
    vec++; if (ev2 !== 1'b0) begin errs++; $display("FAIL sat_early got %b want 0", ev2); end
    pmt2 = 1'b0; tick(1);  // k+2
    vec++; if (ev2 !== 1'b1) begin errs++; $display("FAIL sat_lat got %b want 1", ev2); end
    tick(1);
    vec++; if (ev2 !== 1'b0) begin errs++; $display("FAIL sat_1cyc got %b want 0", ev2); end
    tick(3);
    for (int i = 0; i < 4; i++) begin
      pmt2 = 1'b1; tick(2); pmt2 = 1'b0; tick(4);
    end
    vec++; if (acc2 !== 2'd3) begin errs++; $display("FAIL sat_acc2 got %0d want 3", acc2); end
    vec++; if (ev2_seen - base !== 5) begin
      errs++; $display("FAIL sat_ev2 got %0d want 5", ev2_seen - base);
    end
    vec++; if (gl2 !== 2'd0 || dr2 !== 2'd0) begin
      errs++; $display("FAIL sat_rej got gl=%0d dr=%0d want 0 0", gl2, dr2);
    end
    vec++; if (ei2 !== 1'b1 || eq2 !== 1'b1) begin
      errs++; $display("FAIL sat_tags got %b%b want 11", ei2, eq2);
    end
    clear_all();
    vec++; if (acc2 !== 2'd0) begin errs++; $display("FAIL sat_clr got %0d want 0", acc2); end
  endtask

  task automatic test_reset_mid_qualify();
    int base;
    clear_all();
    base = ev_seen;
    pmt = 1'b1; tick(3);  // now in QUALIFY
    rst = 1'b1; tick(1); rst = 1'b0;
    vec++; if (ev !== 1'b0) begin errs++; $display("FAIL rstq_ev got %b want 0", ev); end
    tick(2); pmt = 1'b0; tick(15);
    vec++; if (ev_seen - base !== 0) begin
      errs++; $display("FAIL rstq_count got %0d want 0", ev_seen - base);
    end
    vec++; if (acc !== 0 || gl !== 0 || dr !== 0) begin
      errs++; $display("FAIL rstq_cnts got %0d/%0d/%0d want 0/0/0", acc, gl, dr);
    end
  endtask

  task automatic test_enable();
    int base;
    clear_all();
    base = ev_seen;
    pmt = 1'b1; tick(3);  // in QUALIFY
    en = 1'b0; tick(1);
    vec++; if (ev !== 1'b0) begin errs++; $display("FAIL en_ev got %b want 0", ev); end
    en = 1'b1; tick(3); pmt = 1'b0; tick(15);
    // Rise entirely while disabled is lost.
    en = 1'b0; pmt = 1'b1; tick(4); en = 1'b1; tick(4); pmt = 1'b0; tick(15);
    vec++; if (ev_seen - base !== 0) begin
      errs++; $display("FAIL en_count got %0d want 0", ev_seen - base);
    end
    vec++; if (acc !== 0 || gl !== 0) begin
      errs++; $display("FAIL en_cnts got acc=%0d gl=%0d want 0 0", acc, gl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_deadtime();
    test_tags();
    test_clear_on_emit();
    test_saturation();
    test_reset_mid_qualify();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
